// File: rtl/sensor_emu_seq.sv
// sensor_emu_seq: run sequencer for a sensor emulator.
// Drives per-frame row-select triggers and an incrementing pattern stream.
module sensor_emu_seq #(
  parameter int PATTERN_WIDTH    = 32,
  parameter int MIN_FRAME_CYCLES = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [31:0]              frame_limit,
  input  logic [31:0]              cycles_per_frame,
  input  logic [PATTERN_WIDTH-1:0] pattern_seed,
  input  logic [PATTERN_WIDTH-1:0] pattern_step,
  input  logic                     gen_sof,
  input  logic                     gen_eof,
  output logic                     rs0,
  output logic                     rs256,
  output logic [PATTERN_WIDTH-1:0] PATTERN_TDATA,
  output logic                     PATTERN_TVALID,
  input  logic                     PATTERN_TREADY,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              frames_sent,
  output logic                     cfg_error,
  output logic                     underrun
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [31:0]              frames_q, frames_d;
  logic [PATTERN_WIDTH-1:0] data_q, data_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     under_q, under_d;
  logic                     in_frame_q, in_frame_d;
  logic [1:0]               drain_q, drain_d;
  logic                     sof_q, eof_q;
  logic                     valid_q, busy_q, done_q;
  logic                     rs0_q, rs256_q;
  logic                     sof_rise, eof_fall;
  logic                     cfg_ok, accept, reject;

  assign sof_rise = gen_sof & ~sof_q;
  assign eof_fall = ~gen_eof & eof_q;
  assign cfg_ok   = (cycles_per_frame >= 32'(MIN_FRAME_CYCLES))
                  & ~cycles_per_frame[0];
  assign accept   = (state_q == IDLE) & start & ~stop & cfg_ok;
  assign reject   = (state_q == IDLE) & start & ~stop & ~cfg_ok;

  always_comb begin
    state_d    = state_q;
    frames_d   = frames_q + {31'd0, sof_rise};
    data_d     = data_q;
    cfg_err_d  = cfg_err_q | reject;
    under_d    = under_q | (sof_rise & ~valid_q);
    in_frame_d = in_frame_q;
    drain_d    = 2'd0;
    if (sof_rise) begin
      in_frame_d = 1'b1;
    end else if (eof_fall) begin
      in_frame_d = 1'b0;
    end
    if (valid_q & PATTERN_TREADY) begin
      data_d = data_q + pattern_step;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = RUN;
          frames_d  = '0;
          cfg_err_d = 1'b0;
          under_d   = 1'b0;
          data_d    = pattern_seed;
        end
      end
      RUN: begin
        if (stop | (sof_rise & (frame_limit != '0)
                    & (frames_d == frame_limit))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // hold off until any frame triggered late has fully ended
        drain_d = (drain_q == 2'd2) ? drain_q : drain_q + 2'd1;
        if ((drain_q >= 2'd2) & ~in_frame_q & ~gen_sof) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      frames_q   <= '0;
      data_q     <= '0;
      cfg_err_q  <= 1'b0;
      under_q    <= 1'b0;
      in_frame_q <= 1'b0;
      drain_q    <= 2'd0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rs0_q      <= 1'b0;
      rs256_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frames_q   <= frames_d;
      data_q     <= data_d;
      cfg_err_q  <= cfg_err_d;
      under_q    <= under_d;
      in_frame_q <= in_frame_d;
      drain_q    <= drain_d;
      sof_q      <= gen_sof;
      eof_q      <= gen_eof;
      valid_q    <= (state_d == RUN) | (state_d == DRAIN);
      busy_q     <= (state_d == RUN) | (state_d == DRAIN);
      done_q     <= (state_d == DONE);
      rs0_q      <= (state_d == RUN) & ~frames_d[0];
      rs256_q    <= (state_d == RUN) & frames_d[0];
    end
  end

  assign rs0            = rs0_q;
  assign rs256          = rs256_q;
  assign PATTERN_TDATA  = data_q;
  assign PATTERN_TVALID = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign frames_sent    = frames_q;
  assign cfg_error      = cfg_err_q;
  assign underrun       = under_q;

endmodule

// File: tb/tb_sensor_emu_seq.sv
// tb_sensor_emu_seq: randomized runs against a frame-level reference model.
// Expectations are queued at stimulus time and consumed by a monitor.
module tb_sensor_emu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop;
  logic [31:0] frame_limit, cycles_per_frame;
  logic [31:0] pattern_seed, pattern_step;
  logic        gen_sof, gen_eof;
  logic        rs0, rs256;
  logic [31:0] PATTERN_TDATA;
  logic        PATTERN_TVALID, PATTERN_TREADY;
  logic        busy, done;
  logic [31:0] frames_sent;
  logic        cfg_error, underrun;

  typedef struct packed {
    logic [31:0] f;
    logic [31:0] d;
  } rec_t;

  logic [1:0]  rs_q[$];
  logic [31:0] beat_q[$];
  rec_t        run_q[$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int last_frames = 0;
  bit frame_open = 0;

  sensor_emu_seq #(
    .PATTERN_WIDTH(32),
    .MIN_FRAME_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .frame_limit(frame_limit),
    .cycles_per_frame(cycles_per_frame),
    .pattern_seed(pattern_seed),
    .pattern_step(pattern_step),
    .gen_sof(gen_sof),
    .gen_eof(gen_eof),
    .rs0(rs0),
    .rs256(rs256),
    .PATTERN_TDATA(PATTERN_TDATA),
    .PATTERN_TVALID(PATTERN_TVALID),
    .PATTERN_TREADY(PATTERN_TREADY),
    .busy(busy),
    .done(done),
    .frames_sent(frames_sent),
    .cfg_error(cfg_error),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: reacts to DUT output events only.
  initial begin
    logic [1:0] prev, cur, e;
    logic [31:0] b;
    rec_t r;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      cur = {rs0, rs256};
      if (reset) begin
        prev = cur;
      end else begin
        if (cur != prev) begin
          if (rs_q.size() == 0) begin
            chk("rs_unexpected_change", cur, prev);
          end else begin
            e = rs_q.pop_front();
            chk("rs_level", cur, e);
          end
        end
        prev = cur;
        if (PATTERN_TVALID && PATTERN_TREADY) begin
          if (beat_q.size() == 0) begin
            chk("beat_unexpected", 1, 0);
          end else begin
            b = beat_q.pop_front();
            chk("beat_tdata", PATTERN_TDATA, b);
          end
        end
        if (done) begin
          done_cnt++;
          if (run_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            r = run_q.pop_front();
            chk("done_frames", frames_sent, r.f);
            chk("done_tdata", PATTERN_TDATA, r.d);
            chk("done_flags", {busy, PATTERN_TVALID, underrun, frame_open}, 0);
          end
        end
      end
    end
  end

  task automatic frame(input bit stop_mid, input bit stop_pre,
                       input bit stray);
    if (stop_pre) begin
      stop = 1'b1;
      tick;
      stop = 1'b0;
    end
    gen_sof = 1'b1;
    PATTERN_TREADY = 1'b1;
    frame_open = 1'b1;
    tick;
    PATTERN_TREADY = 1'b0;
    tick;
    gen_sof = 1'b0;
    repeat (2) tick;
    if (stop_mid) begin
      stop = 1'b1;
      tick;
      stop = 1'b0;
    end
    if (stray) begin
      pattern_seed = $urandom;
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    repeat (2) tick;
    gen_eof = 1'b1;
    repeat (2) tick;
    gen_eof = 1'b0;
    frame_open = 1'b0;
    repeat (3) tick;
  endtask

  // mode 0: frame limit n; 1: stop mid frame n; 2: stop just before frame n+1
  task automatic run(input int mode, input int n, input logic [31:0] seed,
                     input logic [31:0] step, input logic [31:0] cpf);
    int fr, nlev, d0;
    fr = (mode == 2) ? n + 1 : n;
    nlev = (mode == 0) ? n - 1 : n;
    rs_q.push_back(2'b10);
    for (int k = 1; k <= nlev; k++) begin
      rs_q.push_back((k % 2 == 0) ? 2'b10 : 2'b01);
    end
    rs_q.push_back(2'b00);
    for (int k = 0; k < fr; k++) begin
      beat_q.push_back(seed + 32'(k) * step);
    end
    run_q.push_back('{f: 32'(fr), d: seed + 32'(fr) * step});
    frame_limit = (mode == 0) ? 32'(n) : 32'd0;
    cycles_per_frame = cpf;
    pattern_seed = seed;
    pattern_step = step;
    d0 = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_frames", frames_sent, 0);
    chk("start_tdata", PATTERN_TDATA, seed);
    chk("start_flags", {busy, PATTERN_TVALID, cfg_error, underrun}, 4'b1100);
    for (int f = 1; f <= fr; f++) begin
      frame(mode == 1 && f == n, mode == 2 && f == n + 1,
            mode == 0 && f == 1 && n >= 2);
    end
    for (int i = 0; i < 60 && done_cnt == d0; i++) tick;
    repeat (3) tick;
    chk("done_count", done_cnt - d0, 1);
    chk("queues_empty", rs_q.size() + beat_q.size() + run_q.size(), 0);
    rs_q.delete();
    beat_q.delete();
    run_q.delete();
    last_frames = fr;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s, t, v;
    logic [31:0] bad_cpf[4];
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    frame_limit = '0;
    cycles_per_frame = '0;
    pattern_seed = '0;
    pattern_step = '0;
    gen_sof = 1'b0;
    gen_eof = 1'b0;
    PATTERN_TREADY = 1'b0;
    repeat (3) tick;
    chk("reset_outs", {rs0, rs256, PATTERN_TVALID, busy, done,
                       cfg_error, underrun}, 0);
    chk("reset_frames", frames_sent, 0);
    chk("reset_tdata", PATTERN_TDATA, 0);
    reset = 1'b0;
    tick;

    run(0, 3, 32'h10, 32'h1, 32'd64);
    run(1, 5, $urandom, $urandom, 32'd100);
    run(2, 2, $urandom, $urandom, 32'd20);
    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(0, 2)), int'($urandom_range(1, 5)),
          $urandom, $urandom, 32'd20 + 32'd2 * $urandom_range(0, 500));
    end

    // asynchronous reset in the middle of frame 2
    s = $urandom;
    t = $urandom;
    rs_q.push_back(2'b10);
    rs_q.push_back(2'b01);
    rs_q.push_back(2'b10);
    beat_q.push_back(s);
    beat_q.push_back(s + t);
    frame_limit = 0;
    cycles_per_frame = 64;
    pattern_seed = s;
    pattern_step = t;
    start = 1'b1;
    tick;
    start = 1'b0;
    frame(0, 0, 0);
    gen_sof = 1'b1;
    PATTERN_TREADY = 1'b1;
    tick;
    PATTERN_TREADY = 1'b0;
    tick;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outs", {rs0, rs256, PATTERN_TVALID, busy, done,
                             cfg_error, underrun}, 0);
    chk("async_reset_frames", frames_sent, 0);
    chk("async_reset_tdata", PATTERN_TDATA, 0);
    chk("pre_reset_consumed", rs_q.size() + beat_q.size(), 0);
    rs_q.delete();
    beat_q.delete();
    gen_sof = 1'b0;
    frame_open = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    tick;
    run(0, 2, $urandom, $urandom, 32'd40);

    // illegal frame lengths
    bad_cpf[0] = 32'd19;
    bad_cpf[1] = 32'd21;
    bad_cpf[2] = 32'd18;
    bad_cpf[3] = 32'd0;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) v = bad_cpf[i];
      else if ($urandom_range(0, 1) == 1) v = $urandom_range(0, 19);
      else v = $urandom | 32'd1;
      cycles_per_frame = v;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      chk("illegal_cfg_error", cfg_error, 1);
      chk("illegal_idle", {busy, rs0, rs256, PATTERN_TVALID}, 0);
    end

    // start and stop together, then a forced sof while idle
    cycles_per_frame = 64;
    start = 1'b1;
    stop = 1'b1;
    tick;
    start = 1'b0;
    stop = 1'b0;
    tick;
    chk("startstop_idle", {busy, cfg_error, underrun}, 3'b010);
    chk("startstop_frames", frames_sent, last_frames);
    gen_sof = 1'b1;
    repeat (2) tick;
    gen_sof = 1'b0;
    tick;
    chk("forced_sof_underrun", underrun, 1);
    chk("forced_sof_frames", frames_sent, last_frames + 1);
    gen_eof = 1'b1;
    tick;
    gen_eof = 1'b0;
    repeat (2) tick;
    run(2, 1, $urandom, $urandom, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
